// File: rtl/uart_tx_word_serializer.sv
// Word FIFO feeding an LSB-first byte serializer with optional sync byte; first byte valid two cycles after a push into an idle block.
// Backpressure: byte_o holds while byte_ready_i is low; word_ready_o drops when the word FIFO is full.
module uart_tx_word_serializer #(
  parameter int         WORD_FIFO_DEPTH = 4,
  parameter bit         SYNC_EN         = 1'b1,
  parameter logic [7:0] SYNC_BYTE       = 8'hA5
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [31:0]                        word_i,
  input  logic                               word_valid_i,
  output logic                               word_ready_o,
  output logic [7:0]                         byte_o,
  output logic                               byte_valid_o,
  input  logic                               byte_ready_i,
  output logic                               busy_o,
  output logic [$clog2(WORD_FIFO_DEPTH):0]   fifo_count_o
);
  localparam int AW = $clog2(WORD_FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(WORD_FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;
  localparam state_t FIRST = SYNC_EN ? SYNC : DATA;

  logic [31:0]   mem_q [WORD_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  state_t        state_q, state_d;
  logic [31:0]   word_q, word_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    byte_q, byte_d;
  logic          byte_vld_q, byte_vld_d;
  logic          push, pop;
  logic [31:0]   head;
  logic [7:0]    cur_byte;
  logic [1:0]    idx_nxt;

  assign word_ready_o = (count_q != FULL);
  assign push         = word_valid_i && word_ready_o;
  assign head         = mem_q[rd_ptr_q];
  assign idx_nxt      = idx_q + 2'd1;
  assign cur_byte     = (state_q == SYNC) ? SYNC_BYTE : word_q[{idx_q, 3'b000} +: 8];

  // The output register is the presentation stage: SYNC/DATA first fill it,
  // then each accept swaps in the following byte so the stream has no bubbles.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    idx_d      = idx_q;
    byte_d     = byte_q;
    byte_vld_d = byte_vld_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          word_d  = head;
          idx_d   = 2'd0;
          state_d = FIRST;
        end
      end
      SYNC, DATA: begin
        if (!byte_vld_q) begin
          byte_d     = cur_byte;
          byte_vld_d = 1'b1;
        end else if (byte_ready_i) begin
          if (state_q == SYNC) begin
            state_d = DATA;
            idx_d   = 2'd0;
            byte_d  = word_q[7:0];
          end else if (idx_q != 2'd3) begin
            idx_d  = idx_nxt;
            byte_d = word_q[{idx_nxt, 3'b000} +: 8];
          end else if (count_q != '0) begin
            pop     = 1'b1;
            word_d  = head;
            idx_d   = 2'd0;
            state_d = FIRST;
            byte_d  = SYNC_EN ? SYNC_BYTE : head[7:0];
          end else begin
            state_d    = IDLE;
            idx_d      = 2'd0;
            byte_vld_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (!push && pop) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      word_q     <= '0;
      idx_q      <= 2'd0;
      byte_q     <= 8'd0;
      byte_vld_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      byte_q     <= byte_d;
      byte_vld_q <= byte_vld_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push) mem_q[wr_ptr_q] <= word_i;
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = byte_vld_q;
  assign fifo_count_o = count_q;
  assign busy_o       = (state_q != IDLE) || (count_q != '0);
endmodule

// File: tb/tb_uart_tx_word_serializer.sv
// Bench for uart_tx_word_serializer: directed timing checks plus a queue model of the byte stream.
module tb_uart_tx_word_serializer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] word = '0;
  logic        word_valid = 1'b0;
  logic        word_ready;
  logic [7:0]  byte_d;
  logic        byte_valid;
  logic        byte_ready = 1'b0;
  logic        busy;
  logic [2:0]  count;

  logic [31:0] word0 = '0;
  logic        word_valid0 = 1'b0;
  logic        word_ready0;
  logic [7:0]  byte0;
  logic        byte_valid0;
  logic        byte_ready0 = 1'b0;
  logic        busy0;
  logic [2:0]  count0;

  int n_pass = 0;
  int n_total = 0;
  bit rnd_rdy = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  always #5 clk = ~clk;

  uart_tx_word_serializer #(.WORD_FIFO_DEPTH(4), .SYNC_EN(1'b1), .SYNC_BYTE(8'hA5)) dut (
    .clk_i(clk), .rst_i(rst), .word_i(word), .word_valid_i(word_valid), .word_ready_o(word_ready),
    .byte_o(byte_d), .byte_valid_o(byte_valid), .byte_ready_i(byte_ready), .busy_o(busy),
    .fifo_count_o(count));

  uart_tx_word_serializer #(.WORD_FIFO_DEPTH(4), .SYNC_EN(1'b0), .SYNC_BYTE(8'hA5)) dut0 (
    .clk_i(clk), .rst_i(rst), .word_i(word0), .word_valid_i(word_valid0), .word_ready_o(word_ready0),
    .byte_o(byte0), .byte_valid_o(byte_valid0), .byte_ready_i(byte_ready0), .busy_o(busy0),
    .fifo_count_o(count0));

  // Reference model: every accepted word becomes sync byte + 4 bytes, LSB first.
  always @(posedge clk) begin
    if (!rst && word_valid && word_ready) begin
      exp_q.push_back(8'hA5);
      for (int k = 0; k < 4; k++) exp_q.push_back(word[8*k +: 8]);
    end
    if (!rst && byte_valid && byte_ready) got_q.push_back(byte_d);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    bit ok;
    ok = 1'b0;
    word_valid = 1'b1;
    word = w;
    for (int t = 0; t < 300 && !ok; t++) begin
      ok = word_ready;
      if (rnd_rdy) byte_ready = 1'($urandom_range(0, 1));
      step();
    end
    word_valid = 1'b0;
    check("push_accepted", 32'(ok), 32'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 500 && busy; t++) begin
      byte_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
    end
    check("drain_idle", 32'(busy), 32'd0);
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0]  seq0 [8];
    logic [7:0]  w1b [5];
    logic [31:0] w6;
    seq0 = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h04, 8'h03, 8'h02, 8'h01};
    w1b  = '{8'hA5, 8'h44, 8'h33, 8'h22, 8'h11};

    // Reset state
    step(); step();
    rst = 1'b0;
    check("rst_byte", 32'(byte_d), 32'd0);
    check("rst_valid", 32'(byte_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ready", 32'(word_ready), 32'd1);

    // Latency and full-rate sequence
    byte_ready = 1'b1;
    push_word(32'h11223344);
    check("lat_n0_valid", 32'(byte_valid), 32'd0);
    step();
    check("lat_n1_valid", 32'(byte_valid), 32'd0);
    step();
    check("lat_n2_valid", 32'(byte_valid), 32'd1);
    check("lat_n2_byte", 32'(byte_d), 32'hA5);
    for (int k = 1; k < 5; k++) begin
      step();
      check("seq_valid", 32'(byte_valid), 32'd1);
      check("seq_byte", 32'(byte_d), 32'(w1b[k]));
    end
    step();
    check("seq_busy_after", 32'(busy), 32'd0);
    check("seq_valid_after", 32'(byte_valid), 32'd0);

    // Backpressure while 8'h33 is presented
    push_word(32'h11223344);
    step(); step(); step(); step();
    check("bp_pre_byte", 32'(byte_d), 32'h33);
    byte_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_hold_byte", 32'(byte_d), 32'h33);
      check("bp_hold_valid", 32'(byte_valid), 32'd1);
    end
    byte_ready = 1'b1;
    step();
    check("bp_next_byte", 32'(byte_d), 32'h22);
    step();
    check("bp_last_byte", 32'(byte_d), 32'h11);
    step();
    check("bp_busy_after", 32'(busy), 32'd0);
    compare_stream("stream_a");

    // Fill the FIFO under backpressure, producer holds an extra word
    byte_ready = 1'b0;
    push_word(32'h0A0A0A01);
    push_word(32'h0B0B0B02);
    check("pushpop_count", 32'(count), 32'd1);
    push_word(32'h0C0C0C03);
    push_word(32'h0D0D0D04);
    push_word(32'h0E0E0E05);
    check("full_count", 32'(count), 32'd4);
    check("full_ready", 32'(word_ready), 32'd0);
    check("full_busy", 32'(busy), 32'd1);
    w6 = $urandom;
    word = w6;
    word_valid = 1'b1;
    step(); step(); step();
    check("held_count", 32'(count), 32'd4);
    check("held_ready", 32'(word_ready), 32'd0);
    byte_ready = 1'b1;
    for (int t = 0; t < 50 && !word_ready; t++) step();
    check("pop_ready", 32'(word_ready), 32'd1);
    check("pop_count", 32'(count), 32'd3);
    step();
    word_valid = 1'b0;
    check("refill_count", 32'(count), 32'd4);
    drain();
    compare_stream("stream_full");

    // Random words with random byte_ready
    rnd_rdy = 1'b1;
    for (int k = 0; k < 12; k++) push_word($urandom);
    drain();
    rnd_rdy = 1'b0;
    compare_stream("stream_rand");

    // SYNC_EN=0 instance: two pre-queued words stream with no bubble
    check("s0_ready_a", 32'(word_ready0), 32'd1);
    word_valid0 = 1'b1;
    word0 = 32'hDEADBEEF;
    step();
    check("s0_ready_b", 32'(word_ready0), 32'd1);
    word0 = 32'h01020304;
    step();
    word_valid0 = 1'b0;
    check("s0_pushpop_count", 32'(count0), 32'd1);
    step();
    byte_ready0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("s0_valid", 32'(byte_valid0), 32'd1);
      check("s0_byte", 32'(byte0), 32'(seq0[i]));
      step();
    end
    check("s0_busy_after", 32'(busy0), 32'd0);
    check("s0_valid_after", 32'(byte_valid0), 32'd0);

    // Reset while byte 8'h22 is pending, with another word queued
    byte_ready = 1'b1;
    push_word(32'h11223344);
    push_word(32'hAABBCCDD);
    step(); step(); step(); step();
    check("mid_pre_byte", 32'(byte_d), 32'h22);
    rst = 1'b1;
    step();
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
    check("mid_rst_valid", 32'(byte_valid), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_ready", 32'(word_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    step(); step();
    check("mid_quiet_valid", 32'(byte_valid), 32'd0);
    push_word(32'h55667788);
    step(); step();
    check("mid_restart_byte", 32'(byte_d), 32'hA5);
    check("mid_restart_valid", 32'(byte_valid), 32'd1);
    drain();
    compare_stream("stream_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
